// File: rtl/uart_frame_sequencer_pkg.sv
// Shared constants and state encoding for the UART frame sequencer.
package uart_frame_sequencer_pkg;

  localparam logic [7:0] SOF_BYTE    = 8'hAA;
  localparam logic [1:0] ERR_CSUM    = 2'd1;
  localparam logic [1:0] ERR_LEN     = 2'd2;
  localparam logic [1:0] ERR_TIMEOUT = 2'd3;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_CMD,
    ST_LEN,
    ST_PAY,
    ST_CSUM,
    ST_HOLD
  } state_t;

endpackage

// File: rtl/uart_byte_fetch.sv
// Issues single-cycle FIFO pops and presents the popped byte one cycle later.
module uart_byte_fetch (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic       flush,
  input  logic       fifo_empty,
  input  logic [7:0] fifo_q,
  output logic       fifo_rdreq,
  output logic       byte_valid,
  output logic [7:0] rx_byte
);

  logic pending;

  // At most one pop in flight, so the pop rate is one byte per two cycles.
  assign fifo_rdreq = enable && !fifo_empty && !pending && !rst;
  assign byte_valid = pending;
  assign rx_byte    = fifo_q;

  // A flush drops a byte popped in the same cycle so it is never consumed.
  always_ff @(posedge clk) begin
    if (rst) pending <= 1'b0;
    else     pending <= fifo_rdreq && !flush;
  end

endmodule

// File: rtl/uart_frame_sequencer.sv
// Parses SOF/CMD/LEN/PAYLOAD/CSUM frames from the RX FIFO and holds each good frame until acked.
module uart_frame_sequencer
  import uart_frame_sequencer_pkg::*;
#(
  parameter int MAX_LEN        = 8,
  parameter int LEN_W          = 4,
  parameter int TIMEOUT_CYCLES = 50000
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 fifo_empty,
  input  logic [7:0]           fifo_q,
  output logic                 fifo_rdreq,
  output logic                 frame_valid,
  input  logic                 frame_ack,
  output logic [7:0]           frame_cmd,
  output logic [LEN_W-1:0]     frame_len,
  output logic [MAX_LEN*8-1:0] frame_payload,
  output logic                 err_valid,
  output logic [1:0]           err_code,
  output logic                 busy
);

  localparam int TMR_W = (TIMEOUT_CYCLES > 0) ? $clog2(TIMEOUT_CYCLES + 1) : 1;

  state_t             state_q, state_d;
  logic               byte_valid;
  logic [7:0]         rx_byte;
  logic [7:0]         csum_q;
  logic [LEN_W-1:0]   idx_q;
  logic [TMR_W-1:0]   timer_q;
  logic               in_frame;
  logic               timed_out;
  logic               err_d;
  logic [1:0]         code_d;

  uart_byte_fetch u_fetch (
    .clk        (clk),
    .rst        (rst),
    .enable     (state_q != ST_HOLD),
    .flush      (timed_out),
    .fifo_empty (fifo_empty),
    .fifo_q     (fifo_q),
    .fifo_rdreq (fifo_rdreq),
    .byte_valid (byte_valid),
    .rx_byte    (rx_byte)
  );

  assign busy     = (state_q != ST_HUNT);
  assign in_frame = state_q inside {ST_CMD, ST_LEN, ST_PAY, ST_CSUM};
  // A byte arriving in the expiry cycle takes priority over the timeout.
  assign timed_out = (TIMEOUT_CYCLES != 0) && in_frame && !byte_valid &&
                     (timer_q == TMR_W'(TIMEOUT_CYCLES));

  always_ff @(posedge clk) begin
    if (rst) state_q <= ST_HUNT;
    else     state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    err_d   = 1'b0;
    code_d  = err_code;
    if (timed_out) begin
      err_d   = 1'b1;
      code_d  = ERR_TIMEOUT;
      state_d = ST_HUNT;
    end else begin
      case (state_q)
        ST_HUNT: if (byte_valid && rx_byte == SOF_BYTE) state_d = ST_CMD;
        ST_CMD:  if (byte_valid) state_d = ST_LEN;
        ST_LEN:
          if (byte_valid) begin
            if (rx_byte > 8'(MAX_LEN)) begin
              err_d   = 1'b1;
              code_d  = ERR_LEN;
              state_d = ST_HUNT;
            end else if (rx_byte == 8'd0) begin
              state_d = ST_CSUM;
            end else begin
              state_d = ST_PAY;
            end
          end
        ST_PAY:  if (byte_valid && idx_q == frame_len - LEN_W'(1)) state_d = ST_CSUM;
        ST_CSUM:
          if (byte_valid) begin
            if (rx_byte == csum_q) begin
              state_d = ST_HOLD;
            end else begin
              err_d   = 1'b1;
              code_d  = ERR_CSUM;
              state_d = ST_HUNT;
            end
          end
        ST_HOLD: if (frame_ack) state_d = ST_HUNT;
        default: state_d = ST_HUNT;
      endcase
    end
  end

  // Datapath: frame fields double as the held outputs, so they only change while parsing.
  always_ff @(posedge clk) begin
    if (rst) begin
      frame_valid   <= 1'b0;
      frame_cmd     <= '0;
      frame_len     <= '0;
      frame_payload <= '0;
      err_valid     <= 1'b0;
      err_code      <= '0;
      csum_q        <= '0;
      idx_q         <= '0;
      timer_q       <= '0;
    end else begin
      frame_valid <= (state_d == ST_HOLD);
      err_valid   <= err_d;
      err_code    <= code_d;

      if (!in_frame || byte_valid) timer_q <= '0;
      else if (timer_q != '1)      timer_q <= timer_q + TMR_W'(1);

      if (byte_valid) begin
        case (state_q)
          ST_HUNT:
            if (rx_byte == SOF_BYTE) begin
              frame_payload <= '0;
              csum_q        <= '0;
              idx_q         <= '0;
            end
          ST_CMD: begin
            frame_cmd <= rx_byte;
            csum_q    <= csum_q ^ rx_byte;
          end
          ST_LEN:
            if (rx_byte <= 8'(MAX_LEN)) begin
              frame_len <= rx_byte[LEN_W-1:0];
              csum_q    <= csum_q ^ rx_byte;
            end
          ST_PAY: begin
            frame_payload[int'(idx_q)*8 +: 8] <= rx_byte;
            csum_q <= csum_q ^ rx_byte;
            idx_q  <= idx_q + LEN_W'(1);
          end
          default: ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_uart_frame_sequencer.sv
// Scoreboard bench for uart_frame_sequencer: directed byte streams, FIFO model, auto-ack consumer.
module tb_uart_frame_sequencer;

  localparam int MAX_LEN = 8;
  localparam int LEN_W   = 4;
  localparam int TO      = 20;

  logic                 clk = 1'b0;
  logic                 rst;
  logic                 fifo_empty;
  logic [7:0]           fifo_q;
  logic                 fifo_rdreq;
  logic                 frame_valid;
  logic                 frame_ack;
  logic [7:0]           frame_cmd;
  logic [LEN_W-1:0]     frame_len;
  logic [MAX_LEN*8-1:0] frame_payload;
  logic                 err_valid;
  logic [1:0]           err_code;
  logic                 busy;

  typedef struct {
    bit          is_err;
    logic [1:0]  code;
    logic [7:0]  cmd;
    logic [3:0]  len;
    logic [63:0] payload;
  } exp_t;

  exp_t       exp_q[$];
  logic [7:0] fifo[$];
  int checks = 0;
  int errors = 0;
  int consec_cnt = 0;
  int underflow_cnt = 0;
  int hold_rd_cnt = 0;
  int ack_delay = 0;
  int hold_cnt = 0;
  logic prev_rd = 1'b0;
  logic fv_prev = 1'b0;

  uart_frame_sequencer #(.MAX_LEN(MAX_LEN), .LEN_W(LEN_W), .TIMEOUT_CYCLES(TO)) dut (
    .clk           (clk),
    .rst           (rst),
    .fifo_empty    (fifo_empty),
    .fifo_q        (fifo_q),
    .fifo_rdreq    (fifo_rdreq),
    .frame_valid   (frame_valid),
    .frame_ack     (frame_ack),
    .frame_cmd     (frame_cmd),
    .frame_len     (frame_len),
    .frame_payload (frame_payload),
    .err_valid     (err_valid),
    .err_code      (err_code),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%0h required=%0h", name, actual, expected);
    end
  endtask

  // Bytes are given in stream order, right-aligned in the vector.
  task automatic applyStimulus(input logic [95:0] bytes, input int n);
    for (int k = 0; k < n; k++) fifo.push_back(bytes[8*(n-1-k) +: 8]);
    fifo_empty = (fifo.size() == 0);
  endtask

  task automatic expFrame(input logic [7:0] cmd, input logic [3:0] len, input logic [63:0] payload);
    exp_t e;
    e.is_err = 1'b0; e.code = 2'd0; e.cmd = cmd; e.len = len; e.payload = payload;
    exp_q.push_back(e);
  endtask

  task automatic expErr(input logic [1:0] code);
    exp_t e;
    e.is_err = 1'b1; e.code = code; e.cmd = 8'd0; e.len = 4'd0; e.payload = 64'd0;
    exp_q.push_back(e);
  endtask

  task automatic checkReset(input string tag);
    checkOutput({tag, "_frame_valid"}, 64'(frame_valid), 64'd0);
    checkOutput({tag, "_err_valid"},   64'(err_valid),   64'd0);
    checkOutput({tag, "_err_code"},    64'(err_code),    64'd0);
    checkOutput({tag, "_busy"},        64'(busy),        64'd0);
    checkOutput({tag, "_rdreq"},       64'(fifo_rdreq),  64'd0);
    checkOutput({tag, "_cmd"},         64'(frame_cmd),   64'd0);
    checkOutput({tag, "_len"},         64'(frame_len),   64'd0);
    checkOutput({tag, "_payload"},     frame_payload,    64'd0);
  endtask

  task automatic drain(input string name, input int budget);
    int n = 0;
    while (!(exp_q.size() == 0 && fifo_empty && !busy && !frame_valid && !fifo_rdreq) && n < budget) begin
      @(negedge clk);
      n++;
    end
    repeat (2) @(negedge clk);
    if (n >= budget) begin
      checks++;
      errors++;
      $display("[TB] FAIL %s_drain actual=%0d pending expectations required=0 within %0d cycles",
               name, exp_q.size(), budget);
      exp_q.delete();
    end
  endtask

  // FIFO model: read data valid the cycle after the pop.
  always @(posedge clk) begin
    if (fifo_rdreq) begin
      if (prev_rd) consec_cnt++;
      if (fifo.size() == 0) underflow_cnt++;
      else fifo_q <= fifo.pop_front();
    end
    prev_rd = fifo_rdreq;
    fifo_empty <= (fifo.size() == 0);
  end

  // Consumer: acks after ack_delay cycles of HOLD.
  always @(negedge clk) begin
    if (frame_valid && !rst) begin
      frame_ack = (hold_cnt >= ack_delay);
      hold_cnt++;
    end else begin
      frame_ack = 1'b0;
      hold_cnt = 0;
    end
  end

  // Monitor: pops the scoreboard whenever the DUT reports a frame or an error.
  always @(negedge clk) begin
    exp_t e;
    if (!rst) begin
      if (frame_valid && fifo_rdreq) hold_rd_cnt++;
      if (err_valid) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_err actual code=%0d required no output", err_code);
        end else begin
          e = exp_q.pop_front();
          checkOutput("kind_is_err", 64'd1, 64'(e.is_err));
          checkOutput("err_code", 64'(err_code), 64'(e.code));
        end
      end
      if (frame_valid && !fv_prev) begin
        if (exp_q.size() == 0) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_frame actual cmd=%0h required no output", frame_cmd);
        end else begin
          e = exp_q.pop_front();
          checkOutput("kind_is_frame", 64'd0, 64'(e.is_err));
          checkOutput("frame_cmd", 64'(frame_cmd), 64'(e.cmd));
          checkOutput("frame_len", 64'(frame_len), 64'(e.len));
          checkOutput("frame_payload", frame_payload, e.payload);
        end
      end
    end
    fv_prev = frame_valid;
  end

  initial begin
    rst = 1'b1;
    fifo_empty = 1'b1;
    fifo_q = 8'd0;
    frame_ack = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    checkReset("init");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] basic two-byte frame");
    expFrame(8'h10, 4'd2, 64'h6655);
    applyStimulus({8'hAA, 8'h10, 8'h02, 8'h55, 8'h66, 8'h21}, 6);
    drain("t1", 300);

    $display("[TB] leading junk and zero-length frame");
    expFrame(8'h01, 4'd0, 64'h0);
    applyStimulus({8'h00, 8'hFF, 8'hAA, 8'h01, 8'h00, 8'h01}, 6);
    drain("t2", 300);

    $display("[TB] checksum error");
    expErr(2'd1);
    applyStimulus({8'hAA, 8'h10, 8'h02, 8'h55, 8'h66, 8'h22}, 6);
    drain("t3", 300);
    checkOutput("t3_busy_after", 64'(busy), 64'd0);
    checkOutput("t3_frame_valid_after", 64'(frame_valid), 64'd0);

    $display("[TB] length error then recovery");
    expErr(2'd2);
    expFrame(8'h20, 4'd1, 64'h7E);
    applyStimulus({8'hAA, 8'h10, 8'h09, 8'hAA, 8'h20, 8'h01, 8'h7E, 8'h5F}, 8);
    drain("t4", 300);

    $display("[TB] maximum-length frame");
    expFrame(8'h50, 4'd8, 64'h8877665544332211);
    applyStimulus({8'hAA, 8'h50, 8'h08, 8'h11, 8'h22, 8'h33, 8'h44,
                   8'h55, 8'h66, 8'h77, 8'h88, 8'hD0}, 12);
    drain("tmax", 300);

    $display("[TB] inter-byte timeout");
    expErr(2'd3);
    applyStimulus({8'hAA, 8'h10}, 2);
    drain("t5", 300);

    $display("[TB] reset mid-frame");
    applyStimulus({8'hAA, 8'h10, 8'h02, 8'h55}, 4);
    repeat (6) @(negedge clk);
    checkOutput("midrst_busy_before", 64'(busy), 64'd1);
    rst = 1'b1;
    fifo.delete();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    checkReset("midrst");
    @(negedge clk);
    rst = 1'b0;

    $display("[TB] two queued frames with slow ack");
    ack_delay = 50;
    expFrame(8'h30, 4'd3, 64'h030201);
    expFrame(8'h40, 4'd1, 64'hFF);
    applyStimulus({8'hAA, 8'h30, 8'h03, 8'h01, 8'h02, 8'h03, 8'h33,
                   8'hAA, 8'h40, 8'h01, 8'hFF, 8'hBE}, 12);
    drain("t6", 1000);
    ack_delay = 0;

    checkOutput("rdreq_in_hold", 64'(hold_rd_cnt), 64'd0);
    checkOutput("rdreq_consecutive", 64'(consec_cnt), 64'd0);
    checkOutput("fifo_underflow", 64'(underflow_cnt), 64'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
